fetch_stage: RTL and testbench

Instruction fetch stage of the five-stage pipeline. Holds the program counter, issues word requests to instruction memory (variable latency, one request outstanding), and produces the `if_id_type` pipeline register consumed by decode. Handles decode-side stalls via a one-entry pending buffer, and handles branch redirects by discarding in-flight responses.

---
 rtl/fetch_stage_pkg.sv | 34 +++
 rtl/fetch_stage.sv | 142 ++++++++++++++
 tb/tb_fetch_stage.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Shared types and constants for the instruction fetch stage:
//                fetch FSM state encoding, the IF/ID pipeline register layout,
//                the canonical NOP and the program-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_stage_pkg;

    // Word-address width of the program counter.
    localparam int PC_WIDTH = 5;

    // addi x0, x0, 0 -- placed in if_id whenever it carries no real work.
    localparam logic [31:0] NOP_INSTRUCTION = 32'h00000013;

    // READY : nothing outstanding
    // WAIT  : one request outstanding, its response will be kept
    // DROP  : one request outstanding, its response will be discarded
    typedef enum logic [1:0] {
        READY = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_type;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         instruction;
    } if_id_type;

endpackage

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage. Holds the PC, issues one word
//                request at a time to a variable-latency instruction memory,
//                absorbs decode stalls in a one-entry pending buffer and
//                discards in-flight responses on branch redirects.
//  Ports       : clk            - clock, rising edge
//                reset          - synchronous, active-high
//                stall          - hold if_id unchanged
//                redirect_valid - taken branch/jump, flush and refetch
//                redirect_pc    - redirect target word address
//                imem_req       - request strobe (always accepted)
//                imem_addr      - request word address
//                imem_rvalid    - in-order response valid
//                imem_rdata     - instruction word
//                if_id          - pc + instruction to decode
//                if_id_valid    - if_id holds a real instruction
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = 5'd0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output if_id_type           if_id,
    output logic                if_id_valid
);

    fetch_state_type     r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_req_pc;
    logic                r_pend_valid;
    if_id_type           r_pend;
    if_id_type           r_if_id;
    logic                r_if_id_valid;

    fetch_state_type     w_state_next;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic [PC_WIDTH-1:0] w_req_pc_next;
    logic                w_pend_valid_next;
    if_id_type           w_pend_next;
    if_id_type           w_if_id_next;
    logic                w_if_id_valid_next;
    logic                w_keep;
    logic                w_can_issue;
    logic                w_req;
    logic [PC_WIDTH-1:0] w_addr;

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_req_pc_next      = r_req_pc;
        w_pend_valid_next  = r_pend_valid;
        w_pend_next        = r_pend;
        w_if_id_next       = r_if_id;
        w_if_id_valid_next = r_if_id_valid;

        // A response is kept only in WAIT and only when no redirect flushes it.
        w_keep = (r_state == WAIT) && imem_rvalid && !redirect_valid;

        // Pipeline register and pending buffer. Redirect wins over stall.
        if (redirect_valid) begin
            w_if_id_valid_next       = 1'b0;
            w_if_id_next.instruction = NOP_INSTRUCTION;
            w_pend_valid_next        = 1'b0;
        end else if (stall) begin
            if (w_keep) begin
                w_pend_next       = '{pc: r_req_pc, instruction: imem_rdata};
                w_pend_valid_next = 1'b1;
            end
        end else if (r_pend_valid) begin
            w_if_id_next       = r_pend;
            w_if_id_valid_next = 1'b1;
            w_pend_valid_next  = 1'b0;
        end else if (w_keep) begin
            w_if_id_next       = '{pc: r_req_pc, instruction: imem_rdata};
            w_if_id_valid_next = 1'b1;
        end else begin
            w_if_id_valid_next       = 1'b0;
            w_if_id_next.instruction = NOP_INSTRUCTION;
        end

        // A new request may go out once the memory slot frees up, but never
        // while a stalled instruction sits in the pending buffer: that keeps
        // at most one instruction in flight beyond if_id.
        w_can_issue = (r_state == READY) || imem_rvalid;
        w_req       = !reset && w_can_issue && !w_pend_valid_next;
        w_addr      = redirect_valid ? redirect_pc : r_pc;

        if (w_req) begin
            w_state_next  = WAIT;
            w_req_pc_next = w_addr;
            w_pc_next     = w_addr + 5'd1;
        end else if (redirect_valid) begin
            // Only reachable with a request still outstanding and no response
            // yet: remember to throw that response away and refetch later.
            w_pc_next    = redirect_pc;
            w_state_next = DROP;
        end else if ((r_state != READY) && imem_rvalid) begin
            w_state_next = READY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= READY;
            r_pc          <= RESET_PC;
            r_req_pc      <= RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend        <= '{pc: RESET_PC, instruction: NOP_INSTRUCTION};
            r_if_id       <= '{pc: RESET_PC, instruction: NOP_INSTRUCTION};
            r_if_id_valid <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_req_pc      <= w_req_pc_next;
            r_pend_valid  <= w_pend_valid_next;
            r_pend        <= w_pend_next;
            r_if_id       <= w_if_id_next;
            r_if_id_valid <= w_if_id_valid_next;
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = w_addr;
    assign if_id       = r_if_id;
    assign if_id_valid = r_if_id_valid;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage: behavioural instruction
//                memory with per-request latency, an in-order scoreboard of
//                expected deliveries, and a per-cycle vector table for the
//                stall / redirect / reset corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [4:0]  RESET_PC = 5'd0;
    localparam logic [31:0] BASE     = 32'h00100093;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall;
    logic            redirect_valid;
    logic [4:0]      redirect_pc;
    logic            imem_req;
    logic [4:0]      imem_addr;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    if_id_type       if_id;
    logic            if_id_valid;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_id          (if_id),
        .if_id_valid    (if_id_valid)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Memory model state
    logic       mem_busy = 1'b0;
    logic [4:0] mem_addr = '0;
    int         mem_cnt  = 0;

    // Scoreboard state
    if_id_type  exp_q[$];
    logic [4:0] exp_next = RESET_PC;

    logic       obs_req;
    logic [4:0] obs_addr;

    typedef struct {
        logic       rst;
        logic       st;
        logic       rd;
        logic [4:0] rpc;
        int         lat;
        logic       stray;
        logic       ereq;
        logic [4:0] eaddr;
        logic       evalid;
        logic [4:0] epc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [4:0] a);
        return BASE + {27'd0, a};
    endfunction

    function automatic vec_t mk(input logic rst, input logic st, input logic rd,
                                input logic [4:0] rpc, input int lat, input logic stray,
                                input logic ereq, input logic [4:0] eaddr,
                                input logic evalid, input logic [4:0] epc);
        vec_t v;
        v.rst = rst; v.st = st; v.rd = rd; v.rpc = rpc; v.lat = lat; v.stray = stray;
        v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.epc = epc;
        return v;
    endfunction

    // One clock cycle: drive inputs, observe the request, advance the memory
    // model and check any new delivery against the scoreboard.
    task automatic run_cycle(input logic r, input logic s, input logic rd,
                             input logic [4:0] rpc, input int lat, input logic sty);
        logic      real_rv;
        if_id_type e;
        reset          = r;
        stall          = s;
        redirect_valid = rd;
        redirect_pc    = rpc;
        real_rv        = mem_busy && (mem_cnt == 1);
        if (sty) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEADBEEF;
        end else if (real_rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(mem_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
        obs_req  = imem_req;
        obs_addr = imem_addr;
        if (r) begin
            exp_q.delete();
            exp_next = RESET_PC;
        end else if (rd) begin
            exp_q.delete();
            exp_next = rpc;
        end
        if (obs_req) begin
            chk("sb_req_addr", {27'd0, obs_addr}, {27'd0, exp_next});
            chk("sb_one_outstanding", {31'd0, mem_busy && !real_rv}, 32'd0);
            e = {exp_next, word_of(exp_next)};
            exp_q.push_back(e);
            exp_next = exp_next + 5'd1;
        end
        @(posedge clk);
        if (r || real_rv) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (obs_req) begin
            mem_busy = 1'b1;
            mem_addr = obs_addr;
            mem_cnt  = lat;
        end
        #1;
        if (!r && !s && if_id_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sb_unexpected: got pc %0d expected no delivery", if_id.pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", {27'd0, if_id.pc}, {27'd0, e.pc});
                chk("sb_instr", if_id.instruction, e.instruction);
            end
        end
    endtask

    // Two reset cycles then four cycles of 1-cycle-latency streaming.
    task automatic lead_in();
        tbl.push_back(mk(1,0,0,0,1,0, 0,0, 0,0));
        tbl.push_back(mk(1,0,0,0,1,0, 0,0, 0,0));
        tbl.push_back(mk(0,0,0,0,1,0, 1,0, 0,0));
        tbl.push_back(mk(0,0,0,0,1,0, 1,1, 1,0));
        tbl.push_back(mk(0,0,0,0,1,0, 1,2, 1,1));
        tbl.push_back(mk(0,0,0,0,1,0, 1,3, 1,2));
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_rvalid = 1'b0; imem_rdata = '0;

        // Reset state
        run_cycle(1,0,0,0,1,0);
        run_cycle(1,0,0,0,1,0);
        chk("rst_req", {31'd0, obs_req}, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_pc", {27'd0, if_id.pc}, {27'd0, RESET_PC});
        chk("rst_instr", if_id.instruction, NOP_INSTRUCTION);

        // Streaming through the 31 -> 0 wrap, one instruction per cycle
        for (int c = 1; c <= 40; c++) begin
            run_cycle(0,0,0,0,1,0);
            chk($sformatf("stream%0d_req", c), {31'd0, obs_req}, 32'd1);
            chk($sformatf("stream%0d_valid", c), {31'd0, if_id_valid}, {31'd0, c >= 2});
        end

        // Stall held three cycles while a response returns
        lead_in();
        tbl.push_back(mk(0,1,0,0,1,0, 0,0, 1,2));
        tbl.push_back(mk(0,1,0,0,1,0, 0,0, 1,2));
        tbl.push_back(mk(0,1,0,0,1,0, 0,0, 1,2));
        tbl.push_back(mk(0,0,0,0,1,0, 1,4, 1,3));
        tbl.push_back(mk(0,0,0,0,1,0, 1,5, 1,4));
        tbl.push_back(mk(0,0,0,0,1,0, 1,6, 1,5));
        // Redirect to 20 while a 3-cycle request to 4 is outstanding
        lead_in();
        tbl.push_back(mk(0,0,0, 0,3,0, 1,4,  1,3));
        tbl.push_back(mk(0,0,1,20,1,0, 0,0,  0,0));
        tbl.push_back(mk(0,0,0, 0,1,0, 0,0,  0,0));
        tbl.push_back(mk(0,0,0, 0,1,0, 1,20, 0,0));
        tbl.push_back(mk(0,0,0, 0,1,0, 1,21, 1,20));
        tbl.push_back(mk(0,0,0, 0,1,0, 1,22, 1,21));
        // Redirect coinciding with a response under stall
        lead_in();
        tbl.push_back(mk(0,1,1,9,1,0, 1,9,  0,0));
        tbl.push_back(mk(0,0,0,0,1,0, 1,10, 1,9));
        tbl.push_back(mk(0,0,0,0,1,0, 1,11, 1,10));
        // Reset mid-WAIT, then a stray response while READY
        tbl.push_back(mk(1,0,0,0,1,0, 0,0, 0,0));
        tbl.push_back(mk(1,0,0,0,1,0, 0,0, 0,0));
        tbl.push_back(mk(0,0,0,0,3,0, 1,0, 0,0));
        tbl.push_back(mk(1,0,0,0,1,0, 0,0, 0,0));
        tbl.push_back(mk(0,0,0,0,1,1, 1,0, 0,0));
        tbl.push_back(mk(0,0,0,0,1,0, 1,1, 1,0));
        tbl.push_back(mk(0,0,0,0,1,0, 1,2, 1,1));

        for (int i = 0; i < tbl.size(); i++) begin
            run_cycle(tbl[i].rst, tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].lat, tbl[i].stray);
            chk($sformatf("v%0d_req", i), {31'd0, obs_req}, {31'd0, tbl[i].ereq});
            if (tbl[i].ereq)
                chk($sformatf("v%0d_addr", i), {27'd0, obs_addr}, {27'd0, tbl[i].eaddr});
            chk($sformatf("v%0d_valid", i), {31'd0, if_id_valid}, {31'd0, tbl[i].evalid});
            if (tbl[i].evalid || tbl[i].rst)
                chk($sformatf("v%0d_pc", i), {27'd0, if_id.pc}, {27'd0, tbl[i].epc});
            chk($sformatf("v%0d_instr", i), if_id.instruction,
                tbl[i].evalid ? word_of(tbl[i].epc) : NOP_INSTRUCTION);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
